// File: rtl/uart_pkg.sv
// uart_pkg: widths shared by uart_rx, uart_tx and their FIFOs.
//   UART_DATA_WIDTH : default byte width for the UART datapath
//   cnt_width()     : bits needed to hold an occupancy of 0..depth
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Occupancy counters must represent DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready byte stream.
//   data  : payload, driven by master
//   valid : payload present, driven by master
//   ready : sink accepts this cycle, driven by slave
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port register array.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : mem[raddr]
// Storage is deliberately not reset.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through elastic buffer behind uart_rx.
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   flush    : synchronous clear of contents and flags
//   in_if    : byte stream from uart_rx (slave side, drives ready)
//   out_if   : byte stream to consumer (master side, head of FIFO)
//   count    : occupancy 0..DEPTH
//   rts_n    : flow control to remote, high = stop sending (hysteresis)
//   overflow : sticky, push attempted while full
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH        = UART_DATA_WIDTH,
  parameter int DEPTH             = 16,
  parameter int RTS_ASSERT_LEVEL  = 12,
  parameter int RTS_RELEASE_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  uart_rx_fifo_if.slave                 in_if,
  uart_rx_fifo_if.master                out_if,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          rts_n,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] RTS_HI   = CW'(RTS_ASSERT_LEVEL);
  localparam logic [CW-1:0] RTS_LO   = CW'(RTS_RELEASE_LEVEL);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic          full, empty, push, pop, rts_nxt;

  // Handshake flags come only from registered count: no valid->ready path.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign in_if.ready  = !full;
  assign out_if.valid = !empty;

  assign push = in_if.valid && !full;
  assign pop  = out_if.ready && !empty;

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)      cnt_nxt = count + CW'(1);
    else if (pop && !push) cnt_nxt = count - CW'(1);
  end

  // Hysteresis on the post-update occupancy so rts_n reacts the same cycle
  // the threshold is crossed, not one cycle later.
  always_comb begin
    rts_nxt = rts_n;
    if (cnt_nxt >= RTS_HI)      rts_nxt = 1'b1;
    else if (cnt_nxt <= RTS_LO) rts_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rts_n    <= 1'b0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rts_n    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      rts_n <= rts_nxt;
      // uart_rx holds the byte under backpressure; the flag only warns
      // software that the line is outrunning the consumer.
      if (in_if.valid && full) overflow <= 1'b1;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr),
    .wdata (in_if.data),
    .raddr (rd_ptr),
    .rdata (out_if.data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo with a queue-based
// reference model compared every cycle, plus literal checkpoints.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int RHI   = 12;
  localparam int RLO   = 4;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] count;
  logic       rts_n, overflow;

  uart_rx_fifo_if #(.DATA_WIDTH(8)) in_if ();
  uart_rx_fifo_if #(.DATA_WIDTH(8)) out_if ();

  uart_rx_fifo #(
    .DATA_WIDTH(8), .DEPTH(DEPTH),
    .RTS_ASSERT_LEVEL(RHI), .RTS_RELEASE_LEVEL(RLO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .in_if    (in_if),
    .out_if   (out_if),
    .count    (count),
    .rts_n    (rts_n),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit go     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: a plain queue ----------------
  logic [7:0] q[$];
  bit m_rts, m_ovf;

  always @(posedge clk or negedge rstn) begin : model
    bit pu, po;
    if (!rstn) begin
      q.delete(); m_rts = 0; m_ovf = 0;
    end else if (flush) begin
      q.delete(); m_rts = 0; m_ovf = 0;
    end else begin
      pu = in_if.valid && (q.size() < DEPTH);
      po = out_if.ready && (q.size() > 0);
      if (in_if.valid && q.size() == DEPTH) m_ovf = 1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(in_if.data);
      if (q.size() >= RHI)      m_rts = 1;
      else if (q.size() <= RLO) m_rts = 0;
    end
  end

  always @(negedge clk) begin
    if (go && rstn) begin
      chk("m.count",     count,        q.size());
      chk("m.in_ready",  in_if.ready,  q.size() != DEPTH);
      chk("m.out_valid", out_if.valid, q.size() != 0);
      chk("m.rts_n",     rts_n,        m_rts);
      chk("m.overflow",  overflow,     m_ovf);
      if (q.size() != 0) chk("m.out_data", out_if.data, q[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push1(input logic [7:0] b);
    in_if.valid = 1; in_if.data = b;
    step();
    in_if.valid = 0;
  endtask

  int rx_exp = 0;

  // One cycle with a 50% random consumer; returns whether input was taken.
  task automatic cyc(output bit acc);
    out_if.ready = 1'($urandom_range(0, 1));
    if (out_if.valid && out_if.ready) begin
      chk("stream byte", out_if.data, rx_exp[7:0]);
      rx_exp++;
    end
    acc = in_if.valid && in_if.ready;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    int c, e;
    bit acc, took;
    in_if.valid = 0; in_if.data = '0; out_if.ready = 0;

    // 1. reset, idle, single byte
    step(); step();
    rstn = 1; go = 1;
    step();
    chk("rst count", count, 0);
    chk("rst out_valid", out_if.valid, 0);
    chk("rst in_ready", in_if.ready, 1);
    chk("rst rts_n", rts_n, 0);
    chk("rst overflow", overflow, 0);
    push1(8'hA5);
    chk("A5 out_valid", out_if.valid, 1);
    chk("A5 out_data", out_if.data, 8'hA5);
    chk("A5 count", count, 1);
    out_if.ready = 1; step(); out_if.ready = 0;
    chk("A5 popped count", count, 0);

    // 2. fill to full, rts threshold, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      in_if.valid = 1; in_if.data = 8'(i);
      step();
      if (i == 10) chk("rts after 11 pushes", rts_n, 0);
      if (i == 11) chk("rts after 12 pushes", rts_n, 1);
    end
    chk("full count", count, 16);
    chk("full in_ready", in_if.ready, 0);
    in_if.data = 8'h10;
    step();
    chk("overflow set", overflow, 1);
    chk("full hold count", count, 16);
    c = 16; out_if.ready = 1;
    for (int e2 = 0; e2 <= 16; e2++) begin
      chk("drain valid", out_if.valid, 1);
      chk("drain data", out_if.data, e2);
      acc = in_if.valid && in_if.ready;
      step();
      c = c - 1 + int'(acc);
      if (acc) in_if.valid = 0;
      chk("drain count", count, c);
      if (c == 5) chk("rts held at 5", rts_n, 1);
      if (c == 4) chk("rts released at 4", rts_n, 0);
    end
    out_if.ready = 0;
    chk("drained count", count, 0);

    // 3. streaming at count 5 for 40 cycles (pointers wrap)
    for (int i = 0; i < 5; i++) push1(8'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      in_if.valid = 1; in_if.data = 8'(8'h45 + i); out_if.ready = 1;
      chk("stream out", out_if.data, 8'(8'h40 + i));
      step();
      chk("stream count", count, 5);
    end
    in_if.valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stream tail", out_if.data, 8'(8'h68 + i));
      step();
    end
    out_if.ready = 0;

    // 4. full with push+pop same cycle: pop only
    for (int i = 0; i < 16; i++) push1(8'(8'h80 + i));
    chk("refill count", count, 16);
    in_if.valid = 1; in_if.data = 8'h99; out_if.ready = 1;
    chk("full in_ready", in_if.ready, 0);
    step();
    in_if.valid = 0; out_if.ready = 0;
    chk("full pop count", count, 15);
    chk("full pop in_ready", in_if.ready, 1);
    chk("full pop head", out_if.data, 8'h81);

    // 5. flush at count 9 with simultaneous push and pop
    out_if.ready = 1; repeat (6) step(); out_if.ready = 0;
    chk("pre-flush count", count, 9);
    chk("pre-flush rts", rts_n, 1);
    chk("pre-flush ovf", overflow, 1);
    flush = 1; in_if.valid = 1; in_if.data = 8'hEE; out_if.ready = 1;
    step();
    flush = 0; in_if.valid = 0; out_if.ready = 0;
    chk("flush count", count, 0);
    chk("flush out_valid", out_if.valid, 0);
    chk("flush rts", rts_n, 0);
    chk("flush ovf", overflow, 0);
    step();
    chk("flush no byte", count, 0);
    push1(8'h55);
    chk("post-flush head", out_if.data, 8'h55);
    chk("post-flush count", count, 1);
    out_if.ready = 1; step(); out_if.ready = 0;

    // 6. 0x00..0xFF through a 50% random consumer
    for (int b = 0; b < 256; b++) begin
      in_if.valid = 1; in_if.data = 8'(b);
      took = 0;
      for (int k = 0; k < 200 && !took; k++) cyc(took);
      if (!took) chk("stream accept", 0, 1);
      in_if.valid = 0;
      repeat (3) cyc(acc);
    end
    for (int k = 0; k < 2000 && rx_exp < 256; k++) cyc(acc);
    out_if.ready = 0;
    chk("stream received", rx_exp, 256);
    chk("stream overflow", overflow, 0);

    // 7. asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) push1(8'(8'hC0 + i));
    chk("pre-reset count", count, 3);
    #2 rstn = 0;
    #1;
    chk("async rst count", count, 0);
    chk("async rst out_valid", out_if.valid, 0);
    chk("async rst in_ready", in_if.ready, 1);
    step();
    rstn = 1;
    step();
    chk("after rst count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
